// File: rtl/prog_mem_pkg.sv
// Shared constants and state encoding for the prog_mem program memory.
package prog_mem_pkg;

    localparam int DEF_AW    = 16;
    localparam int DEF_DW    = 16;
    localparam int DEF_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_DONE = ST_DONE;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Single-port synchronous RAM, DEPTH x DW, with registered read data.
// Accesses to addresses at or above DEPTH never write and read back zero.
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int          IW      = idx_width(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic          in_range;

    assign in_range = {1'b0, addr} < DEPTH_W;

    // Read data holds between reads; only the output register is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= in_range ? mem[addr[IW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (en && we && in_range) begin
            mem[addr[IW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Program memory with a registered CPU read port and a streaming load port.
// Optional macro PROG_MEM_CHECKSUM_EN adds the ld_sum running checksum.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] Ma,
    input  logic          Mre,
    output logic [DW-1:0] Md,
    output logic          Mvalid,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW-1:0] ld_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          ld_err
`ifdef PROG_MEM_CHECKSUM_EN
    ,
    output logic [DW-1:0] ld_sum
`endif
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [1:0]    state;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [AW-1:0] count;
    logic [AW-1:0] wr_addr;
    logic          wr_in_range;
    logic          beat;
    logic          last_beat;
    logic          rd_en;
    logic          start_ok;

    assign ld_ready    = (state == S_LOAD);
    assign ld_busy     = (state != S_IDLE);
    assign ld_done     = (state == S_DONE);
    assign beat        = ld_valid && ld_ready;
    assign wr_addr     = base + count;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
    assign last_beat   = (count == (len - AW'(1)));
    assign rd_en       = Mre && (state == S_IDLE);
    assign start_ok    = ld_start && (state == S_IDLE);

    // The array port is shared: load beats only exist outside IDLE, reads only in IDLE.
    prog_mem_array #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (beat || rd_en),
        .we    (beat),
        .addr  (beat ? wr_addr : Ma),
        .wdata (ld_data),
        .rdata (Md)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            Mvalid <= 1'b0;
        end else begin
            Mvalid <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            base   <= '0;
            len    <= '0;
            count  <= '0;
            ld_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        base   <= ld_base;
                        len    <= ld_len;
                        count  <= '0;
                        ld_err <= 1'b0;
                        state  <= (ld_len != '0) ? S_LOAD : S_DONE;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        count <= count + AW'(1);
                        if (!wr_in_range) begin
                            ld_err <= 1'b1;
                        end
                        if (last_beat) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    // Dropped out-of-range words still count toward the checksum.
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            ld_sum <= '0;
        end else if (beat) begin
            ld_sum <= ld_sum + ld_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed loads/reads plus random traffic,
// compared every cycle against a transaction-level model of the memory.
module tb_prog_mem;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Ma;
    logic          Mre;
    logic [DW-1:0] Md;
    logic          Mvalid;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic [AW-1:0] ld_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;
    logic          ld_err;
`ifdef PROG_MEM_CHECKSUM_EN
    logic [DW-1:0] ld_sum;
`endif

    int tests = 0;
    int fails = 0;

    prog_mem #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Ma       (Ma),
        .Mre      (Mre),
        .Md       (Md),
        .Mvalid   (Mvalid),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_len   (ld_len),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_busy  (ld_busy),
        .ld_done  (ld_done),
        .ld_err   (ld_err)
`ifdef PROG_MEM_CHECKSUM_EN
        ,
        .ld_sum   (ld_sum)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: memory image with known-bits, plus load session bookkeeping.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    bit            loading;
    bit            finishing;
    bit            exp_mvalid;
    bit            exp_err;
    bit            md_known;
    bit            check_en;
    logic [DW-1:0] exp_md;
    logic [DW-1:0] exp_sum;
    logic [AW-1:0] l_base;
    logic [AW-1:0] l_next;
    int            words_left;

    logic [DW-1:0] wq [$];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    task automatic modelStep();
        logic [AW-1:0] a;
        if (reset) begin
            loading    = 0;
            finishing  = 0;
            exp_mvalid = 0;
            exp_err    = 0;
            exp_md     = '0;
            md_known   = 1;
            exp_sum    = '0;
            check_en   = 1;
            return;
        end
        if (Mre && !loading && !finishing) begin
            exp_mvalid = 1;
            if (int'(Ma) >= DEPTH) begin
                exp_md   = '0;
                md_known = 1;
            end else begin
                exp_md   = m_mem[Ma[7:0]];
                md_known = m_known[Ma[7:0]];
            end
        end else begin
            exp_mvalid = 0;
        end
        if (finishing) begin
            finishing = 0;
        end else if (loading) begin
            if (ld_valid) begin
                a = l_base + l_next;
                if (int'(a) < DEPTH) begin
                    m_mem[a[7:0]]   = ld_data;
                    m_known[a[7:0]] = 1;
                end else begin
                    exp_err = 1;
                end
                exp_sum    = exp_sum + ld_data;
                l_next     = l_next + 16'd1;
                words_left = words_left - 1;
                if (words_left == 0) begin
                    loading   = 0;
                    finishing = 1;
                end
            end
        end else if (ld_start) begin
            l_base     = ld_base;
            l_next     = '0;
            words_left = int'(ld_len);
            exp_err    = 0;
            exp_sum    = '0;
            if (ld_len == '0) finishing = 1;
            else              loading   = 1;
        end
    endtask

    task automatic checkOutput();
        if (!check_en) return;
        cmp("Mvalid", {31'd0, Mvalid}, {31'd0, exp_mvalid});
        cmp("ld_ready", {31'd0, ld_ready}, {31'd0, loading});
        cmp("ld_busy", {31'd0, ld_busy}, {31'd0, loading || finishing});
        cmp("ld_done", {31'd0, ld_done}, {31'd0, finishing});
        cmp("ld_err", {31'd0, ld_err}, {31'd0, exp_err});
        if (md_known) cmp("Md", {16'd0, Md}, {16'd0, exp_md});
`ifdef PROG_MEM_CHECKSUM_EN
        cmp("ld_sum", {16'd0, ld_sum}, {16'd0, exp_sum});
`endif
    endtask

    initial begin
        check_en = 0;
        md_known = 0;
        foreach (m_known[i]) m_known[i] = 0;
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    task automatic applyStimulus(input bit rst, input bit mre, input logic [AW-1:0] ma,
                                 input bit start, input logic [AW-1:0] base,
                                 input logic [AW-1:0] len, input bit valid,
                                 input logic [DW-1:0] data);
        reset    = rst;
        Mre      = mre;
        Ma       = ma;
        ld_start = start;
        ld_base  = base;
        ld_len   = len;
        ld_valid = valid;
        ld_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, '0, 0, '0, '0, 0, '0);
    endtask

    task automatic doRead(input logic [AW-1:0] addr, input logic [DW-1:0] expv, input string name);
        applyStimulus(0, 1, addr, 0, '0, '0, 0, '0);
        cmp(name, {16'd0, Md}, {16'd0, expv});
        cmp({name, "_valid"}, {31'd0, Mvalid}, 32'd1);
    endtask

    // Streams wq starting at base; abort_at >= 0 asserts reset in place of that beat.
    task automatic doLoad(input logic [AW-1:0] base, input bit gaps, input int abort_at,
                          input bit rd_during, output int dones);
        dones = 0;
        applyStimulus(0, 0, '0, 1, base, AW'(wq.size()), 0, '0);
        dones += int'(ld_done);
        for (int i = 0; i < wq.size(); i++) begin
            if (i == abort_at) begin
                applyStimulus(1, 0, '0, 0, '0, '0, 0, '0);
                dones += int'(ld_done);
                idleCycle();
                dones += int'(ld_done);
                return;
            end
            if (gaps) begin
                applyStimulus(0, rd_during, base, 0, '0, '0, 0, '0);
                dones += int'(ld_done);
            end
            applyStimulus(0, rd_during, base, 0, '0, '0, 1, wq[i]);
            dones += int'(ld_done);
            if (rd_during) cmp("mre_in_load", {31'd0, Mvalid}, 32'd0);
        end
        for (int c = 0; c < 6 && ld_busy; c++) begin
            idleCycle();
            dones += int'(ld_done);
        end
        cmp("load_back_idle", {31'd0, ld_busy}, 32'd0);
    endtask

    initial begin
        int d;
        logic [AW-1:0] rb;
        logic [AW-1:0] rl;

        applyStimulus(1, 0, '0, 0, '0, '0, 0, '0);
        applyStimulus(1, 0, '0, 0, '0, '0, 0, '0);
        cmp("rst_md", {16'd0, Md}, 32'd0);
        cmp("rst_mvalid", {31'd0, Mvalid}, 32'd0);
        cmp("rst_busy", {31'd0, ld_busy}, 32'd0);
        cmp("rst_ready", {31'd0, ld_ready}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, AW'(i), 0, '0, '0, 0, '0);
            cmp("read_after_rst_valid", {31'd0, Mvalid}, 32'd1);
        end
        idleCycle();
        cmp("mvalid_drop", {31'd0, Mvalid}, 32'd0);

        wq = '{16'h00DE, 16'h00AD, 16'h00BE, 16'h00EF};
        doLoad(16'h0010, 0, -1, 0, d);
        cmp("load1_dones", d, 32'd1);
        cmp("load1_err", {31'd0, ld_err}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
        cmp("load1_sum", {16'd0, ld_sum}, 32'h0338);
`endif
        doRead(16'h0010, 16'h00DE, "load1_rd0");
        doRead(16'h0011, 16'h00AD, "load1_rd1");
        doRead(16'h0012, 16'h00BE, "load1_rd2");
        doRead(16'h0013, 16'h00EF, "load1_rd3");

        doLoad(16'h0020, 1, -1, 0, d);
        cmp("load2_dones", d, 32'd1);
        doRead(16'h0020, 16'h00DE, "load2_rd0");
        doRead(16'h0023, 16'h00EF, "load2_rd3");

        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        doLoad(16'h00FE, 0, -1, 0, d);
        cmp("oor_err", {31'd0, ld_err}, 32'd1);
        doRead(16'h00FE, 16'h1111, "oor_rd_fe");
        doRead(16'h00FF, 16'h2222, "oor_rd_ff");
        doRead(16'h0100, 16'h0000, "oor_rd_100");
        doRead(16'h0101, 16'h0000, "oor_rd_101");

        wq.delete();
        doLoad(16'h0030, 0, -1, 0, d);
        cmp("len0_dones", d, 32'd1);
        cmp("len0_err_cleared", {31'd0, ld_err}, 32'd0);

        wq = '{16'h0005, 16'h0006, 16'h0007};
        doLoad(16'h0030, 0, -1, 1, d);
        cmp("rdload_dones", d, 32'd1);
        doRead(16'h0032, 16'h0007, "rdload_rd2");

        wq = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        doLoad(16'h0040, 0, -1, 0, d);
        wq = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
        doLoad(16'h0040, 0, 2, 0, d);
        cmp("abort_dones", d, 32'd0);
        cmp("abort_busy", {31'd0, ld_busy}, 32'd0);
        doRead(16'h0040, 16'h00B0, "abort_rd0");
        doRead(16'h0041, 16'h00B1, "abort_rd1");
        doRead(16'h0042, 16'h00A2, "abort_rd2");
        doRead(16'h0043, 16'h00A3, "abort_rd3");

        wq = '{16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
        doLoad(16'hFFFE, 0, -1, 0, d);
        cmp("wrap_err", {31'd0, ld_err}, 32'd1);
        doRead(16'h0000, 16'h00C3, "wrap_rd0");
        doRead(16'h0001, 16'h00C4, "wrap_rd1");

        for (int n = 0; n < 600; n++) begin
            rb = ($urandom_range(0, 9) == 0) ? 16'hFFFD : AW'($urandom_range(0, 270));
            rl = AW'($urandom_range(0, 6));
            applyStimulus($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 300)), $urandom_range(0, 3) == 0,
                          rb, rl, 1'($urandom_range(0, 1)), DW'($urandom));
        end
        for (int c = 0; c < 20 && ld_busy; c++) idleCycle();
        cmp("final_idle", {31'd0, ld_busy}, 32'd0);
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
